// File: rtl/step_scheduler_if.sv
// rtl/step_scheduler_if.sv - move-command handshake between command logic and step_scheduler
interface step_scheduler_if #(
  parameter int POS_W    = 32,
  parameter int PERIOD_W = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [POS_W-1:0]    cmd_target;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (output cmd_valid, output cmd_target, output cmd_period, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, input cmd_period, output cmd_ready);
endinterface

// File: rtl/step_scheduler.sv
// rtl/step_scheduler.sv - motor position sequencer: timed moves to a target or external step/dir
module step_scheduler #(
  parameter int POS_W      = 32,
  parameter int PERIOD_W   = 16,
  parameter int MIN_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_ctrl,
  input  logic             ext_step_rise,
  input  logic             ext_dir,
  input  logic             abort,
  step_scheduler_if.slave  cmd,
  output logic [POS_W-1:0] cur_pos,
  output logic             step_pulse,
  output logic             dir,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t              state, state_nxt;
  logic [POS_W-1:0]    target, target_nxt, pos_nxt, pos_step, diff;
  logic [PERIOD_W-1:0] period, period_nxt, timer, timer_nxt, period_eff;
  logic                dir_nxt, step_nxt, accept;

  // Commands are only taken when idle and the external pins do not own the position
  assign cmd.cmd_ready = (state == IDLE) && !ext_ctrl;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (state != IDLE);
  // FINISH lasts exactly one cycle, so done is a single pulse per move
  assign done          = (state == FINISH);

  assign period_eff = (cmd.cmd_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : cmd.cmd_period;
  assign pos_step   = dir ? cur_pos + POS_W'(1) : cur_pos - POS_W'(1);
  // Signed distance; its sign bit picks the direction, so exactly half-range goes down
  assign diff       = cmd.cmd_target - cur_pos;

  // Next-state and datapath decisions for the move sequencer
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    period_nxt = period;
    timer_nxt  = timer;
    pos_nxt    = cur_pos;
    dir_nxt    = dir;
    step_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          target_nxt = cmd.cmd_target;
          period_nxt = period_eff;
          if (diff == '0) begin
            state_nxt = FINISH;
          end else begin
            dir_nxt   = !diff[POS_W-1];
            timer_nxt = period_eff - PERIOD_W'(1);
            state_nxt = RUN;
          end
        end else if (ext_ctrl && ext_step_rise) begin
          pos_nxt  = ext_dir ? cur_pos + POS_W'(1) : cur_pos - POS_W'(1);
          dir_nxt  = ext_dir;
          step_nxt = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = FINISH;
        end else if (timer == '0) begin
          pos_nxt   = pos_step;
          step_nxt  = 1'b1;
          timer_nxt = period - PERIOD_W'(1);
          if (pos_step == target) state_nxt = FINISH;
        end else begin
          timer_nxt = timer - PERIOD_W'(1);
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any move in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_pos    <= '0;
      target     <= '0;
      period     <= '0;
      timer      <= '0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_pos    <= pos_nxt;
      target     <= target_nxt;
      period     <= period_nxt;
      timer      <= timer_nxt;
      dir        <= dir_nxt;
      step_pulse <= step_nxt;
    end
  end

endmodule

// File: tb/tb_step_scheduler.sv
// tb/tb_step_scheduler.sv - scoreboard bench for step_scheduler
module tb_step_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, ext_ctrl, ext_step_rise, ext_dir, abort;
  logic [31:0] cur_pos;
  logic        step_pulse, dir, busy, done;

  step_scheduler_if #(.POS_W(32), .PERIOD_W(16)) cmd_bus ();

  step_scheduler #(.POS_W(32), .PERIOD_W(16), .MIN_PERIOD(4)) dut (
    .clk(clk), .rst_n(rst_n), .ext_ctrl(ext_ctrl), .ext_step_rise(ext_step_rise),
    .ext_dir(ext_dir), .abort(abort), .cmd(cmd_bus),
    .cur_pos(cur_pos), .step_pulse(step_pulse), .dir(dir), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [31:0] pos;
    logic        dir;
    logic        stp;
    logic        dn;
  } ev_t;

  ev_t         sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pos = 0;
  logic        m_dir = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic [31:0] p, input logic d, input logic s, input logic dn);
    ev_t e;
    e.cyc = c; e.pos = p; e.dir = d; e.stp = s; e.dn = dn;
    sb.push_back(e);
  endtask

  // Monitor: every step_pulse/done cycle must match the next expected event
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        ev_t m;
        m = sb.pop_front();
        total++; bad++;
        $display("FAIL missed_event: got none want event at cyc %0d pos %0h", m.cyc, m.pos);
      end
      if (step_pulse || done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got step=%0b done=%0b pos=%0h want none (cyc %0d)",
                   step_pulse, done, cur_pos, cyc);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("ev_cycle", cyc, e.cyc);
          chk("ev_pos", cur_pos, e.pos);
          chk("ev_dir", {31'b0, dir}, {31'b0, e.dir});
          chk("ev_step", {31'b0, step_pulse}, {31'b0, e.stp});
          chk("ev_done", {31'b0, done}, {31'b0, e.dn});
        end
      end
    end
  end

  // abort_k > 0: abort lands on the edge that would have made step abort_k
  task automatic do_move(input logic [31:0] tgt, input logic [15:0] per, input int unsigned abort_k,
                         input bit ext_noise);
    int unsigned p, e0, n, n_run, last;
    logic [31:0] d;
    logic        up;
    chk("ready_before_cmd", {31'b0, cmd_bus.cmd_ready}, 32'd1);
    p  = (per < 4) ? 4 : per;
    d  = tgt - m_pos;
    e0 = cyc + 1;
    if (d == 0) begin
      push(e0, m_pos, m_dir, 1'b0, 1'b1);
      last = e0;
    end else begin
      up    = ($signed(d) > 0);
      m_dir = up;
      n     = up ? d : (32'd0 - d);
      n_run = (abort_k != 0) ? abort_k - 1 : n;
      for (int unsigned k = 1; k <= n_run; k++) begin
        m_pos = up ? m_pos + 1 : m_pos - 1;
        push(e0 + k * p, m_pos, m_dir, 1'b1, (abort_k == 0) && (k == n));
      end
      if (abort_k != 0) begin
        last = e0 + abort_k * p;
        push(last, m_pos, m_dir, 1'b0, 1'b1);
      end else begin
        last = e0 + n * p;
      end
    end
    cmd_bus.cmd_valid  = 1'b1;
    cmd_bus.cmd_target = tgt;
    cmd_bus.cmd_period = per;
    @(negedge clk);
    cmd_bus.cmd_valid  = 1'b0;
    cmd_bus.cmd_target = ~tgt;
    cmd_bus.cmd_period = 16'd1;
    chk("ready_low_after_accept", {31'b0, cmd_bus.cmd_ready}, 32'd0);
    if (ext_noise) begin
      ext_ctrl = 1'b1;
      for (int i = 0; i < 3; i++) begin
        ext_dir = i[0];
        ext_step_rise = 1'b1;
        @(negedge clk);
      end
      ext_step_rise = 1'b0;
      ext_ctrl = 1'b0;
    end
    if (abort_k != 0) begin
      while (cyc < last - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    while (cyc < last + 1) @(negedge clk);
    chk("busy_after_move", {31'b0, busy}, 32'd0);
    chk("ready_after_move", {31'b0, cmd_bus.cmd_ready}, 32'd1);
    chk("pos_after_move", cur_pos, m_pos);
  endtask

  task automatic ext_pulses(input logic d, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      ext_dir = d;
      ext_step_rise = 1'b1;
      m_pos = d ? m_pos + 1 : m_pos - 1;
      m_dir = d;
      push(cyc + 1, m_pos, m_dir, 1'b1, 1'b0);
      @(negedge clk);
      chk("ext_ready_low", {31'b0, cmd_bus.cmd_ready}, 32'd0);
      chk("ext_not_busy", {31'b0, busy}, 32'd0);
    end
    ext_step_rise = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    logic [31:0] tgt;
    rst_n = 1'b0; ext_ctrl = 1'b0; ext_step_rise = 1'b0; ext_dir = 1'b0; abort = 1'b0;
    cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_target = '0; cmd_bus.cmd_period = '0;
    repeat (2) @(negedge clk);
    chk("rst_pos", cur_pos, 32'd0);
    chk("rst_dir", {31'b0, dir}, 32'd0);
    chk("rst_step", {31'b0, step_pulse}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, cmd_bus.cmd_ready}, 32'd1);
    ext_ctrl = 1'b1;
    #1 chk("rst_ready_ext", {31'b0, cmd_bus.cmd_ready}, 32'd0);
    ext_ctrl = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_move(32'd5, 16'd10, 0, 0);
    do_move(32'd2, 16'd6, 0, 0);
    do_move(32'hFFFF_FFFE, 16'd1, 0, 0);
    do_move(m_pos, 16'd7, 0, 0);
    do_move(32'd1000, 16'd8, 3, 0);
    for (int i = 0; i < 3; i++) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle_busy", {31'b0, busy}, 32'd0);
      chk("abort_idle_pos", cur_pos, m_pos);
    end
    do_move(m_pos + 32'h8000_0000, 16'd4, 3, 0);

    ext_ctrl = 1'b1;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_target = m_pos + 5;
    cmd_bus.cmd_period = 16'd4;
    @(negedge clk);
    ext_pulses(1'b1, 3);
    ext_pulses(1'b0, 2);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    ext_ctrl = 1'b0;
    ext_step_rise = 1'b1;
    @(negedge clk);
    ext_step_rise = 1'b0;
    @(negedge clk);
    chk("ext_ignored_pos", cur_pos, m_pos);

    do_move(m_pos + 3, 16'd5, 0, 1);

    for (int r = 0; r < 20; r++) begin
      int unsigned n, ak;
      logic [31:0] d;
      tgt = m_pos + $urandom_range(0, 12) - 6;
      d = tgt - m_pos;
      n = ($signed(d) > 0) ? d : (32'd0 - d);
      ak = 0;
      if (n > 0 && $urandom_range(0, 3) == 0) ak = $urandom_range(1, n);
      do_move(tgt, 16'($urandom_range(0, 12)), ak, 0);
      if ($urandom_range(0, 2) == 0) begin
        ext_ctrl = 1'b1;
        ext_pulses(1'($urandom_range(0, 1)), $urandom_range(1, 3));
        ext_ctrl = 1'b0;
        @(negedge clk);
      end
    end

    rst_n = 1'b0;
    #1 chk("rst2_pos", cur_pos, 32'd0);
    sb.delete();
    m_pos = 0; m_dir = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e0 = cyc + 1;
    for (int unsigned k = 1; k <= 3; k++) push(e0 + k * 5, k, 1'b1, 1'b1, 1'b0);
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_target = 32'd10; cmd_bus.cmd_period = 16'd5;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    while (cyc < e0 + 15) @(negedge clk);
    chk("pre_reset_pos", cur_pos, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pos", cur_pos, 32'd0);
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_step", {31'b0, step_pulse}, 32'd0);
    chk("async_rst_done", {31'b0, done}, 32'd0);
    chk("async_rst_dir", {31'b0, dir}, 32'd0);
    chk("async_rst_ready", {31'b0, cmd_bus.cmd_ready}, 32'd1);
    chk("queue_before_reset", sb.size(), 32'd0);
    sb.delete();
    m_pos = 0; m_dir = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_move(32'd4, 16'd4, 0, 0);

    repeat (4) @(negedge clk);
    chk("queue_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
